// File: rtl/aw_write_order_arbiter_pkg.sv
// Shared types and helpers for the AW write-order arbiter slice.
package aw_write_order_arbiter_pkg;

    // Arbitration FSM: pick a master, present its address, push its ID.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        PUSH = 2'd2
    } arb_state_t;

    // Width of a master index; never narrower than one bit.
    function automatic int id_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    localparam int DEFAULT_NUM_MASTERS = 2;
    localparam int DEFAULT_ID_WIDTH    = id_width(DEFAULT_NUM_MASTERS);

    // Master ID as pushed into the write-data ordering queue.
    typedef logic [DEFAULT_ID_WIDTH-1:0] master_id_t;

endpackage

// File: rtl/aw_write_order_arbiter_if.sv
// AW handshake bundle between the masters/slave side and the arbiter.
// 'master' is the environment side (requesting masters and the downstream
// slave); 'slave' is the arbiter that answers the requests.
interface aw_write_order_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_WIDTH    = 1
);
    logic [NUM_MASTERS-1:0] M_AWVALID;
    logic [NUM_MASTERS-1:0] M_AWREADY;
    logic                   S_AWVALID;
    logic                   S_AWREADY;
    logic                   Split_Lock;
    logic [ID_WIDTH-1:0]    Sel_Master;

    modport master (
        output M_AWVALID, S_AWREADY, Split_Lock,
        input  M_AWREADY, S_AWVALID, Sel_Master
    );

    modport slave (
        input  M_AWVALID, S_AWREADY, Split_Lock,
        output M_AWREADY, S_AWVALID, Sel_Master
    );
endinterface

// File: rtl/aw_write_order_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first masked requester at or after ptr_i,
// wrapping from N-1 back to 0.
module rr_priority_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic [N-1:0] mask_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);
    logic [N-1:0] eff_s;
    logic [W-1:0] cand_s;

    assign eff_s = req_i & mask_i;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = {W{1'b0}};
        cand_s  = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            cand_s = W'((int'(ptr_i) + i) % N);
            if (eff_s[cand_s]) begin
                valid_o = 1'b1;
                idx_o   = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end
endmodule

// File: rtl/aw_write_order_arbiter.sv
// Round-robin AW arbiter: grants one master at a time, forwards its AWVALID to
// the slave and pushes the granted master ID into the write-data ordering
// queue. Throttles on a full queue and on the outstanding-burst cap.
module aw_write_order_arbiter
    import aw_write_order_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ID_WIDTH        = id_width(NUM_MASTERS),
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    aw_write_order_arbiter_if.slave aw,
    input  logic                 Queue_Is_Full,
    input  logic                 Write_Data_Finsh,
    output logic                 AW_Access_Grant,
    output logic [ID_WIDTH-1:0]  Granted_Master_ID,
    output logic [CNT_WIDTH-1:0] Outstanding_Cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [ID_WIDTH-1:0]  ID_LAST  = ID_WIDTH'(NUM_MASTERS - 1);
    localparam logic [ID_WIDTH-1:0]  ID_ZERO  = ID_WIDTH'(0);
    localparam logic [ID_WIDTH-1:0]  ID_ONE   = ID_WIDTH'(1);

    arb_state_t             state_q;
    logic [ID_WIDTH-1:0]    sel_q;
    logic [ID_WIDTH-1:0]    rr_ptr_q;
    logic                   lock_q;
    logic                   s_awvalid_q;
    logic                   grant_q;
    logic [ID_WIDTH-1:0]    gid_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;

    logic [NUM_MASTERS-1:0] cand_mask_s;
    logic                   pick_valid_s;
    logic [ID_WIDTH-1:0]    pick_idx_s;
    logic                   eligible_s;
    logic [ID_WIDTH-1:0]    sel_next_s;
    logic [NUM_MASTERS-1:0] awready_s;

    rr_priority_picker #(
        .N (NUM_MASTERS),
        .W (ID_WIDTH)
    ) u_picker (
        .req_i   (aw.M_AWVALID),
        .ptr_i   (rr_ptr_q),
        .mask_i  (cand_mask_s),
        .valid_o (pick_valid_s),
        .idx_o   (pick_idx_s)
    );

    // While a split is locked only the lock holder (kept in rr_ptr_q) may win.
    always_comb begin
        cand_mask_s = {NUM_MASTERS{1'b1}};
        if (lock_q) begin
            cand_mask_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << rr_ptr_q;
        end else begin
            cand_mask_s = {NUM_MASTERS{1'b1}};
        end
    end

    assign eligible_s = pick_valid_s && !Queue_Is_Full && (cnt_q < CNT_MAX);
    assign sel_next_s = (sel_q == ID_LAST) ? ID_ZERO : (sel_q + ID_ONE);

    // Only the granted master sees the slave's AWREADY, and only while in ADDR.
    always_comb begin
        awready_s = {NUM_MASTERS{1'b0}};
        if (state_q == ADDR) begin
            awready_s[sel_q] = aw.S_AWREADY;
        end else begin
            awready_s = {NUM_MASTERS{1'b0}};
        end
    end

    // Outstanding count: push increments, finish decrements, both cancel;
    // a finish with nothing outstanding is dropped.
    always_comb begin
        cnt_d = cnt_q;
        case ({grant_q, Write_Data_Finsh})
            2'b10:   cnt_d = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
            2'b01:   cnt_d = (cnt_q == CNT_ZERO) ? cnt_q : (cnt_q - CNT_ONE);
            default: cnt_d = cnt_q;
        endcase
    end

    // Arbitration FSM with registered handshake, push strobe and counter.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            sel_q       <= ID_ZERO;
            rr_ptr_q    <= ID_ZERO;
            lock_q      <= 1'b0;
            s_awvalid_q <= 1'b0;
            grant_q     <= 1'b0;
            gid_q       <= ID_ZERO;
            cnt_q       <= CNT_ZERO;
        end else begin
            grant_q <= 1'b0;
            cnt_q   <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (eligible_s) begin
                        sel_q       <= pick_idx_s;
                        s_awvalid_q <= 1'b1;
                        state_q     <= ADDR;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ADDR: begin
                    // Valid is never withdrawn; wait for the slave.
                    if (aw.S_AWREADY) begin
                        s_awvalid_q <= 1'b0;
                        lock_q      <= aw.Split_Lock;
                        rr_ptr_q    <= aw.Split_Lock ? sel_q : sel_next_s;
                        grant_q     <= 1'b1;
                        gid_q       <= sel_q;
                        state_q     <= PUSH;
                    end else begin
                        state_q <= ADDR;
                    end
                end
                PUSH: begin
                    state_q <= IDLE;
                end
                default: begin
                    s_awvalid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign aw.S_AWVALID      = s_awvalid_q;
    assign aw.M_AWREADY      = awready_s;
    assign aw.Sel_Master     = sel_q;
    assign AW_Access_Grant   = grant_q;
    assign Granted_Master_ID = gid_q;
    assign Outstanding_Cnt   = cnt_q;
endmodule

// File: tb/tb_aw_write_order_arbiter.sv
// Directed bench for aw_write_order_arbiter: reset, fairness, split lock,
// queue-full throttle, outstanding cap and mid-burst reset.
module tb_aw_write_order_arbiter;
    import aw_write_order_arbiter_pkg::*;

    logic       ACLK;
    logic       ARESETN;
    logic       Queue_Is_Full;
    logic       Write_Data_Finsh;
    logic       AW_Access_Grant;
    master_id_t Granted_Master_ID;
    logic [2:0] Outstanding_Cnt;

    int n_vec = 0;
    int n_err = 0;

    aw_write_order_arbiter_if #(.NUM_MASTERS(2), .ID_WIDTH(1)) aw_if ();

    aw_write_order_arbiter #(
        .NUM_MASTERS     (2),
        .ID_WIDTH        (1),
        .MAX_OUTSTANDING (4)
    ) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .aw                (aw_if),
        .Queue_Is_Full     (Queue_Is_Full),
        .Write_Data_Finsh  (Write_Data_Finsh),
        .AW_Access_Grant   (AW_Access_Grant),
        .Granted_Master_ID (Granted_Master_ID),
        .Outstanding_Cnt   (Outstanding_Cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // One full burst with S_AWREADY=1: ADDR cycle, PUSH cycle, back to IDLE.
    task automatic burst(input string tag, input logic [0:0] exp_sel, input logic fin);
        step();
        chk({tag, "_valid"}, 32'(aw_if.S_AWVALID), 32'd1);
        chk({tag, "_sel"}, 32'(aw_if.Sel_Master), 32'(exp_sel));
        step();
        chk({tag, "_push"}, 32'(AW_Access_Grant), 32'd1);
        chk({tag, "_id"}, 32'(Granted_Master_ID), 32'(exp_sel));
        Write_Data_Finsh = fin;
        step();
        Write_Data_Finsh = 1'b0;
        chk({tag, "_push_end"}, 32'(AW_Access_Grant), 32'd0);
    endtask

    initial begin
        ARESETN = 1'b0;
        Queue_Is_Full = 1'b0;
        Write_Data_Finsh = 1'b0;
        aw_if.M_AWVALID = 2'b00;
        aw_if.S_AWREADY = 1'b0;
        aw_if.Split_Lock = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(aw_if.S_AWVALID), 32'd0);
        chk("rst_push", 32'(AW_Access_Grant), 32'd0);
        chk("rst_cnt", 32'(Outstanding_Cnt), 32'd0);
        chk("rst_sel", 32'(aw_if.Sel_Master), 32'd0);
        chk("rst_ready", 32'(aw_if.M_AWREADY), 32'd0);
        ARESETN = 1'b1;

        // Single request from master 0.
        aw_if.M_AWVALID = 2'b01;
        aw_if.S_AWREADY = 1'b1;
        step();
        chk("single_valid", 32'(aw_if.S_AWVALID), 32'd1);
        chk("single_ready", 32'(aw_if.M_AWREADY), 32'd1);
        step();
        chk("single_push", 32'(AW_Access_Grant), 32'd1);
        chk("single_id", 32'(Granted_Master_ID), 32'd0);
        chk("single_valid_drop", 32'(aw_if.S_AWVALID), 32'd0);
        aw_if.M_AWVALID = 2'b11;
        step();
        chk("single_cnt", 32'(Outstanding_Cnt), 32'd1);

        // Fairness: both requesting, pointer now at 1.
        burst("rr0", 1'b1, 1'b1);
        burst("rr1", 1'b0, 1'b1);
        burst("rr2", 1'b1, 1'b1);
        burst("rr3", 1'b0, 1'b1);
        chk("rr_cnt", 32'(Outstanding_Cnt), 32'd1);

        // Split lock on master 0.
        burst("pre_split", 1'b1, 1'b1);
        aw_if.Split_Lock = 1'b1;
        burst("split_lock", 1'b0, 1'b1);
        aw_if.Split_Lock = 1'b0;
        aw_if.M_AWVALID = 2'b10;
        step();
        chk("lock_wait0", 32'(aw_if.S_AWVALID), 32'd0);
        step();
        chk("lock_wait1", 32'(aw_if.S_AWVALID), 32'd0);
        aw_if.M_AWVALID = 2'b11;
        burst("split_hold", 1'b0, 1'b1);
        burst("split_free", 1'b1, 1'b1);

        // Queue full in IDLE blocks, rising during ADDR does not.
        Queue_Is_Full = 1'b1;
        step();
        chk("full_idle0", 32'(aw_if.S_AWVALID), 32'd0);
        step();
        chk("full_idle1", 32'(aw_if.S_AWVALID), 32'd0);
        Queue_Is_Full = 1'b0;
        aw_if.S_AWREADY = 1'b0;
        step();
        chk("full_addr_valid", 32'(aw_if.S_AWVALID), 32'd1);
        chk("full_addr_ready", 32'(aw_if.M_AWREADY), 32'd0);
        Queue_Is_Full = 1'b1;
        step();
        chk("full_hold_valid", 32'(aw_if.S_AWVALID), 32'd1);
        chk("full_hold_push", 32'(AW_Access_Grant), 32'd0);
        aw_if.S_AWREADY = 1'b1;
        #1;
        chk("full_hs_ready", 32'(aw_if.M_AWREADY), 32'd1);
        step();
        chk("full_push", 32'(AW_Access_Grant), 32'd1);
        chk("full_id", 32'(Granted_Master_ID), 32'd0);
        Write_Data_Finsh = 1'b1;
        step();
        Write_Data_Finsh = 1'b0;
        Queue_Is_Full = 1'b0;
        chk("full_cnt", 32'(Outstanding_Cnt), 32'd1);

        // Outstanding cap of 4.
        burst("cap_a", 1'b1, 1'b0);
        chk("cap_cnt2", 32'(Outstanding_Cnt), 32'd2);
        burst("cap_b", 1'b0, 1'b0);
        chk("cap_cnt3", 32'(Outstanding_Cnt), 32'd3);
        burst("cap_c", 1'b1, 1'b1);
        chk("cap_both", 32'(Outstanding_Cnt), 32'd3);
        burst("cap_d", 1'b0, 1'b0);
        chk("cap_cnt4", 32'(Outstanding_Cnt), 32'd4);
        step();
        chk("cap_stall0", 32'(aw_if.S_AWVALID), 32'd0);
        step();
        chk("cap_stall1", 32'(aw_if.S_AWVALID), 32'd0);
        chk("cap_hold4", 32'(Outstanding_Cnt), 32'd4);
        Write_Data_Finsh = 1'b1;
        step();
        Write_Data_Finsh = 1'b0;
        chk("cap_fin", 32'(Outstanding_Cnt), 32'd3);
        burst("cap_resume", 1'b1, 1'b0);
        chk("cap_cnt4b", 32'(Outstanding_Cnt), 32'd4);
        Write_Data_Finsh = 1'b1;
        step();
        Write_Data_Finsh = 1'b0;
        burst("pre_rst", 1'b0, 1'b1);
        chk("pre_rst_cnt", 32'(Outstanding_Cnt), 32'd3);

        // Reset while master 1 waits in ADDR.
        aw_if.S_AWREADY = 1'b0;
        step();
        chk("rstaddr_valid", 32'(aw_if.S_AWVALID), 32'd1);
        chk("rstaddr_sel", 32'(aw_if.Sel_Master), 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("rstmid_valid", 32'(aw_if.S_AWVALID), 32'd0);
        chk("rstmid_push", 32'(AW_Access_Grant), 32'd0);
        chk("rstmid_cnt", 32'(Outstanding_Cnt), 32'd0);
        step();
        chk("rstmid_push2", 32'(AW_Access_Grant), 32'd0);
        ARESETN = 1'b1;
        aw_if.S_AWREADY = 1'b1;
        burst("post_rst", 1'b0, 1'b0);
        chk("post_rst_cnt", 32'(Outstanding_Cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
